// File: rtl/add_if.sv
// Operand/result bundle for the pipelined adder.
// The master drives operands; the slave (the adder) returns the sum and flags.
interface add_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH:0]   C;
  logic             out_valid;
  logic             carry;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, A, B,
    input  C, out_valid, carry, zero, ovf
  );

  modport slave (
    input  in_valid, A, B,
    output C, out_valid, carry, zero, ovf
  );
endinterface

// File: rtl/add.sv
// Two-stage pipelined unsigned adder: low half summed in stage 1, high half plus
// the low-half carry in stage 2. Produces a WIDTH+1-bit result and carry/zero/ovf flags.
module add #(
  parameter int WIDTH = 8
) (
  input logic  clk,
  input logic  rst_n,
  add_if.slave bus
);
  localparam int L = WIDTH / 2;
  localparam int H = WIDTH - L;

  logic [L-1:0]   lo_sum_q, lo_sum_d;
  logic           lo_cy_q, lo_cy_d;
  logic [H-1:0]   a_hi_q, a_hi_d;
  logic [H-1:0]   b_hi_q, b_hi_d;
  logic           v1_q, v1_d;
  logic [WIDTH:0] c_q, c_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
  logic [H:0]     hi_sum;

  // Stage 1: datapath registers only load on valid input so bubbles hold the last operands.
  always_comb begin
    lo_sum_d = lo_sum_q;
    lo_cy_d  = lo_cy_q;
    a_hi_d   = a_hi_q;
    b_hi_d   = b_hi_q;
    v1_d     = bus.in_valid;
    if (bus.in_valid) begin
      {lo_cy_d, lo_sum_d} = {1'b0, bus.A[L-1:0]} + {1'b0, bus.B[L-1:0]};
      a_hi_d              = bus.A[WIDTH-1:L];
      b_hi_d              = bus.B[WIDTH-1:L];
    end
  end

  assign hi_sum = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{H{1'b0}}, lo_cy_q};

  // Stage 2: result and flags only update for valid results, so C holds across bubbles.
  always_comb begin
    c_d         = c_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = v1_q;
    if (v1_q) begin
      c_d     = {hi_sum, lo_sum_q};
      carry_d = hi_sum[H];
      zero_d  = ~|{hi_sum, lo_sum_q};
      ovf_d   = (a_hi_q[H-1] == b_hi_q[H-1]) && (hi_sum[H-1] != a_hi_q[H-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum_q    <= '0;
      lo_cy_q     <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      v1_q        <= 1'b0;
      c_q         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      lo_sum_q    <= lo_sum_d;
      lo_cy_q     <= lo_cy_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      v1_q        <= v1_d;
      c_q         <= c_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.C         = c_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_add.sv
// Scoreboard bench for the pipelined adder: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every valid output.
module tb_add;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH:0] c;
    logic           carry;
    logic           zero;
    logic           ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_if #(.WIDTH(WIDTH)) bus ();
  add #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t           sb[$];
  exp_t           mon_e;
  logic [WIDTH:0] hold_c = '0;
  int             checks   = 0;
  int             failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int c, input bit cy, input bit z, input bit o);
    exp_t e;
    e.c     = (WIDTH+1)'(c);
    e.carry = cy;
    e.zero  = z;
    e.ovf   = o;
    return e;
  endfunction

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input exp_t e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    sb.push_back(e);
  endtask

  task automatic bubble();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 8'hA5;
    bus.B        = 8'h5A;
  endtask

  task automatic drain();
    int n = 0;
    bubble();
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_C"},         32'(bus.C),         32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_zero"},      32'(bus.zero),      32'd0);
    check({tag, "_carry"},     32'(bus.carry),     32'd0);
    check({tag, "_ovf"},       32'(bus.ovf),       32'd0);
  endtask

  // Monitor: valid outputs pop the scoreboard; bubbles must hold the last valid C.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("C",     32'(bus.C),     32'(mon_e.c));
          check("carry", 32'(bus.carry), 32'(mon_e.carry));
          check("zero",  32'(bus.zero),  32'(mon_e.zero));
          check("ovf",   32'(bus.ovf),   32'(mon_e.ovf));
          hold_c = mon_e.c;
        end
      end else begin
        check("C_hold_on_bubble", 32'(bus.C), 32'(hold_c));
      end
    end else begin
      hold_c = '0;
    end
  end

  initial begin
    // Reset with live inputs driven
    bus.in_valid = 1'b1;
    bus.A        = 8'd5;
    bus.B        = 8'd7;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    end

    // Basic back-to-back sums
    issue(8'd1, 8'd1, mk(2, 0, 0, 0));
    issue(8'd2, 8'd3, mk(5, 0, 0, 0));
    issue(8'd0, 8'd0, mk(0, 0, 1, 0));

    // Carry-out and signed overflow
    issue(8'd255, 8'd1,   mk(256, 1, 0, 0));
    issue(8'd128, 8'd128, mk(256, 1, 0, 1));
    issue(8'd255, 8'd255, mk(510, 1, 0, 0));
    issue(8'd240, 8'd15,  mk(255, 0, 0, 0));
    issue(8'd127, 8'd1,   mk(128, 0, 0, 1));

    // Carry across the half boundary
    issue(8'h0F, 8'h01, mk(16'h010, 0, 0, 0));
    issue(8'h55, 8'hAA, mk(16'h0FF, 0, 0, 0));
    drain();

    // Bubble in the middle: C must hold 7 during the gap
    issue(8'd3, 8'd4, mk(7, 0, 0, 0));
    bubble();
    issue(8'd10, 8'd20, mk(30, 0, 0, 0));
    drain();

    // Mid-stream reset discards both in-flight results
    issue(8'd9, 8'd9, mk(18, 0, 0, 0));
    issue(8'd1, 8'd2, mk(3, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_cleared("midrst");
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Recovery after reset
    issue(8'h80, 8'h7F, mk(255, 0, 0, 0));
    issue(8'hFF, 8'h01, mk(256, 1, 0, 0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
